// File: rtl/robot_pkg.sv
// Shared types for the navigation controllers: motor drive codes, route commands
// and route FSM states, plus the line-follow steering decision.
package robot_pkg;

   localparam int PERIOD_DEFAULT = 2_000_000;

   typedef enum logic [2:0] {
      DRV_STOP,
      DRV_FWD,
      DRV_GLEFT,
      DRV_SLEFT,
      DRV_GRIGHT,
      DRV_SRIGHT
   } drive_t;

   typedef enum logic [1:0] {
      CMD_STRAIGHT,
      CMD_LEFT,
      CMD_RIGHT,
      CMD_STOP
   } cmd_t;

   typedef enum logic [2:0] {
      IDLE,
      FOLLOW,
      CROSS_EXIT,
      TURN,
      DONE,
      FAULT
   } route_state_t;

   // Steering for patterns with a usable line position; 000 and 111 are handled by the caller.
   function automatic drive_t follow_drive(input logic [2:0] lmr);
      drive_t drv;
      case (lmr)
         3'b110:  drv = DRV_GLEFT;
         3'b100:  drv = DRV_SLEFT;
         3'b011:  drv = DRV_GRIGHT;
         3'b001:  drv = DRV_SRIGHT;
         default: drv = DRV_FWD;
      endcase
      return drv;
   endfunction

endpackage

// File: rtl/drive_encoder.sv
// Maps a symbolic drive code onto the reset/direction pair of each motorcontrol channel.
module drive_encoder
   import robot_pkg::*;
(
   input  drive_t drive,
   output logic   l_rst,
   output logic   l_dir,
   output logic   r_rst,
   output logic   r_dir
);

   always_comb begin
      {l_rst, l_dir, r_rst, r_dir} = 4'b1010;
      case (drive)
         DRV_FWD:    {l_rst, l_dir, r_rst, r_dir} = 4'b0101;
         DRV_GLEFT:  {l_rst, l_dir, r_rst, r_dir} = 4'b1001;
         DRV_SLEFT:  {l_rst, l_dir, r_rst, r_dir} = 4'b0001;
         DRV_GRIGHT: {l_rst, l_dir, r_rst, r_dir} = 4'b0110;
         DRV_SRIGHT: {l_rst, l_dir, r_rst, r_dir} = 4'b0100;
         default:    {l_rst, l_dir, r_rst, r_dir} = 4'b1010;
      endcase
   end

endmodule

// File: rtl/route_controller.sv
// Frame-synchronous line follower that counts crossings and executes a pre-loaded
// list of straight/left/right/stop commands using timed spins.
module route_controller
   import robot_pkg::*;
#(
   parameter int PERIOD          = PERIOD_DEFAULT,
   parameter int MAX_STEPS       = 8,
   parameter int CROSS_CONFIRM   = 2,
   parameter int LOST_FRAMES     = 25,
   parameter int TURN_MIN_FRAMES = 10,
   parameter int TURN_MAX_FRAMES = 100
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sensor_l,
   input  logic                   sensor_m,
   input  logic                   sensor_r,
   input  logic [20:0]            count_in,
   output logic                   count_reset,
   input  logic [2*MAX_STEPS-1:0] route_cmd,
   input  logic [3:0]             route_len,
   input  logic                   start,
   output logic                   motor_l_reset,
   output logic                   motor_r_reset,
   output logic                   motor_l_direction,
   output logic                   motor_r_direction,
   output logic                   busy,
   output logic                   done,
   output logic                   fault,
   output logic [2:0]             cross_idx
);

   localparam int LOST_W  = $clog2(LOST_FRAMES + 1);
   localparam int CROSS_W = $clog2(CROSS_CONFIRM + 1);
   localparam int TURN_W  = $clog2(TURN_MAX_FRAMES + 1);

   localparam logic [20:0]        LAST_COUNT = 21'(PERIOD - 1);
   localparam logic [LOST_W-1:0]  LOST_LAST  = LOST_W'(LOST_FRAMES - 1);
   localparam logic [CROSS_W-1:0] CROSS_LAST = CROSS_W'(CROSS_CONFIRM - 1);
   localparam logic [TURN_W-1:0]  TURN_MIN_LAST = TURN_W'(TURN_MIN_FRAMES - 1);
   localparam logic [TURN_W-1:0]  TURN_LAST  = TURN_W'(TURN_MAX_FRAMES - 1);
   localparam logic [2:0]         IDX_LAST   = 3'(MAX_STEPS - 1);
   localparam logic [3:0]         LEN_MAX    = 4'(MAX_STEPS);

   route_state_t           state;
   drive_t                 drive_q;
   logic [LOST_W-1:0]      lost_cnt;
   logic [CROSS_W-1:0]     cross_cnt;
   logic [TURN_W-1:0]      turn_cnt;
   logic [2*MAX_STEPS-1:0] route_q;
   logic [3:0]             route_len_q;
   logic [2:0]             lmr;
   logic                   tick;
   cmd_t                   slot;

   // ">=" lets an overflowed count recover instead of running off to 2^21.
   assign count_reset = reset | (count_in >= LAST_COUNT);
   assign tick        = (count_in >= LAST_COUNT) & ~reset;
   assign lmr         = {sensor_l, sensor_m, sensor_r};
   assign slot        = cmd_t'(route_q[{cross_idx, 1'b0} +: 2]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         drive_q     <= DRV_STOP;
         busy        <= 1'b0;
         done        <= 1'b0;
         fault       <= 1'b0;
         cross_idx   <= '0;
         lost_cnt    <= '0;
         cross_cnt   <= '0;
         turn_cnt    <= '0;
         route_q     <= '0;
         route_len_q <= '0;
      end else if (start && !busy) begin
         // Launch is accepted on any cycle; the drive stays STOP until the first tick.
         state       <= FOLLOW;
         busy        <= 1'b1;
         done        <= 1'b0;
         fault       <= 1'b0;
         cross_idx   <= '0;
         lost_cnt    <= '0;
         cross_cnt   <= '0;
         turn_cnt    <= '0;
         route_q     <= route_cmd;
         route_len_q <= (route_len > LEN_MAX) ? LEN_MAX : route_len;
      end else if (tick) begin
         case (state)
            FOLLOW: begin
               if (lmr == 3'b000) begin
                  cross_cnt <= '0;
                  lost_cnt  <= lost_cnt + 1'b1;
                  if (lost_cnt == LOST_LAST) begin
                     state   <= FAULT;
                     drive_q <= DRV_STOP;
                     busy    <= 1'b0;
                     fault   <= 1'b1;
                  end
               end else if (lmr == 3'b111) begin
                  lost_cnt <= '0;
                  drive_q  <= DRV_FWD;
                  if (cross_cnt == CROSS_LAST) begin
                     cross_cnt <= '0;
                     if (({1'b0, cross_idx} == route_len_q) || (slot == CMD_STOP)) begin
                        state   <= DONE;
                        drive_q <= DRV_STOP;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                     end else begin
                        if (cross_idx != IDX_LAST) cross_idx <= cross_idx + 3'd1;
                        turn_cnt <= '0;
                        case (slot)
                           CMD_LEFT: begin
                              state   <= TURN;
                              drive_q <= DRV_SLEFT;
                           end
                           CMD_RIGHT: begin
                              state   <= TURN;
                              drive_q <= DRV_SRIGHT;
                           end
                           default: state <= CROSS_EXIT;
                        endcase
                     end
                  end else begin
                     cross_cnt <= cross_cnt + 1'b1;
                  end
               end else begin
                  lost_cnt  <= '0;
                  cross_cnt <= '0;
                  drive_q   <= follow_drive(lmr);
               end
            end
            CROSS_EXIT: begin
               if (lmr != 3'b111) state <= FOLLOW;
            end
            // The middle sensor only ends a spin once the robot has turned past the old line.
            TURN: begin
               turn_cnt <= turn_cnt + 1'b1;
               if ((turn_cnt >= TURN_MIN_LAST) && sensor_m) begin
                  state    <= FOLLOW;
                  drive_q  <= DRV_FWD;
                  turn_cnt <= '0;
                  lost_cnt <= '0;
               end else if (turn_cnt == TURN_LAST) begin
                  state   <= FAULT;
                  drive_q <= DRV_STOP;
                  busy    <= 1'b0;
                  fault   <= 1'b1;
               end
            end
            default: drive_q <= DRV_STOP;
         endcase
      end
   end

   drive_encoder u_drive_encoder (
      .drive (drive_q),
      .l_rst (motor_l_reset),
      .l_dir (motor_l_direction),
      .r_rst (motor_r_reset),
      .r_dir (motor_r_direction)
   );

endmodule

// File: tb/tb_route_controller.sv
// Bench for route_controller with a short frame, a free-running timebase model
// and a scoreboard of expected per-frame outputs.
module tb_route_controller;

   localparam int PERIOD = 100;

   localparam logic [3:0] M_STOP   = 4'b1010;
   localparam logic [3:0] M_FWD    = 4'b0101;
   localparam logic [3:0] M_GLEFT  = 4'b1001;
   localparam logic [3:0] M_SLEFT  = 4'b0001;
   localparam logic [3:0] M_GRIGHT = 4'b0110;
   localparam logic [3:0] M_SRIGHT = 4'b0100;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        sensor_l = 1'b0;
   logic        sensor_m = 1'b0;
   logic        sensor_r = 1'b0;
   logic [20:0] count_in = '0;
   logic        count_reset;
   logic [15:0] route_cmd = '0;
   logic [3:0]  route_len = '0;
   logic        start = 1'b0;
   logic        motor_l_reset, motor_r_reset, motor_l_direction, motor_r_direction;
   logic        busy, done, fault;
   logic [2:0]  cross_idx;

   int vectors = 0;
   int miscompares = 0;
   logic [9:0] sb[$];

   route_controller #(.PERIOD(PERIOD)) dut (
      .clk               (clk),
      .reset             (reset),
      .sensor_l          (sensor_l),
      .sensor_m          (sensor_m),
      .sensor_r          (sensor_r),
      .count_in          (count_in),
      .count_reset       (count_reset),
      .route_cmd         (route_cmd),
      .route_len         (route_len),
      .start             (start),
      .motor_l_reset     (motor_l_reset),
      .motor_r_reset     (motor_r_reset),
      .motor_l_direction (motor_l_direction),
      .motor_r_direction (motor_r_direction),
      .busy              (busy),
      .done              (done),
      .fault             (fault),
      .cross_idx         (cross_idx)
   );

   always #5 clk = ~clk;

   // Timebase model: free-running counter cleared by the controller.
   always @(posedge clk) count_in <= count_reset ? 21'd0 : count_in + 21'd1;

   function automatic logic [12:0] step(input logic [2:0] lmr, input logic [3:0] drv,
                                        input logic b, input logic d, input logic f,
                                        input logic [2:0] idx);
      return {lmr, drv, b, d, f, idx};
   endfunction

   function automatic logic [9:0] observed();
      return {motor_l_reset, motor_l_direction, motor_r_reset, motor_r_direction,
              busy, done, fault, cross_idx};
   endfunction

   // Drives one frame of sensors, queues its expected outcome and waits for the next frame start.
   task automatic apply_step(input logic [12:0] s);
      int n = 0;
      {sensor_l, sensor_m, sensor_r} = s[12:10];
      sb.push_back(s[9:0]);
      do begin
         @(negedge clk);
         n++;
      end while (count_in != 21'd0 && n < 4 * PERIOD);
      if (count_in != 21'd0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL frame_timeout: count_in %0d, wanted 0", count_in);
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic test_reset();
      int n;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      vectors++;
      if (count_reset !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL reset_count_reset: got %b expected 1", count_reset);
      end
      vectors++;
      if (observed() !== {M_STOP, 3'b000, 3'd0}) begin
         miscompares++;
         $display("[TB] FAIL reset_outputs: got %b expected %b", observed(), {M_STOP, 6'd0});
      end
      reset = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (count_in != 21'd50 && n < 4 * PERIOD);
      vectors++;
      if (count_in !== 21'd50 || count_reset !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL count_reset_mid: got %b at count %0d expected 0 at 50", count_reset, count_in);
      end
      n = 0;
      do begin @(negedge clk); n++; end while (count_in != 21'd99 && n < 4 * PERIOD);
      vectors++;
      if (count_in !== 21'd99 || count_reset !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL count_reset_wrap: got %b at count %0d expected 1 at 99", count_reset, count_in);
      end
      @(negedge clk);
      vectors++;
      if (count_in !== 21'd0 || observed() !== {M_STOP, 6'd0}) begin
         miscompares++;
         $display("[TB] FAIL idle_frame: got %b count %0d expected %b count 0", observed(), count_in, {M_STOP, 6'd0});
      end
   endtask

   task automatic test_route();
      logic [12:0] steps[$];
      logic [9:0] exp;
      route_cmd = 16'h0001;
      route_len = 4'd2;
      pulse_start();
      vectors++;
      if (observed() !== {M_STOP, 3'b100, 3'd0}) begin
         miscompares++;
         $display("[TB] FAIL route_start: got %b expected %b", observed(), {M_STOP, 3'b100, 3'd0});
      end
      steps.push_back(step(3'b010, M_FWD, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b111, M_FWD, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b111, M_SLEFT, 1, 0, 0, 3'd1));
      for (int k = 1; k <= 10; k++)
         steps.push_back(step((k >= 3) ? 3'b010 : 3'b100, (k < 10) ? M_SLEFT : M_FWD, 1, 0, 0, 3'd1));
      steps.push_back(step(3'b111, M_FWD, 1, 0, 0, 3'd1));
      steps.push_back(step(3'b111, M_FWD, 1, 0, 0, 3'd2));
      steps.push_back(step(3'b111, M_FWD, 1, 0, 0, 3'd2));
      steps.push_back(step(3'b010, M_FWD, 1, 0, 0, 3'd2));
      steps.push_back(step(3'b111, M_FWD, 1, 0, 0, 3'd2));
      steps.push_back(step(3'b111, M_STOP, 0, 1, 0, 3'd2));
      steps.push_back(step(3'b010, M_STOP, 0, 1, 0, 3'd2));
      foreach (steps[i]) begin
         apply_step(steps[i]);
         exp = sb.pop_front();
         vectors++;
         if (observed() !== exp) begin
            miscompares++;
            $display("[TB] FAIL route step %0d: got %b expected %b", i, observed(), exp);
         end
      end
   endtask

   task automatic test_steering();
      logic [12:0] steps[$];
      logic [9:0] exp;
      pulse_start();
      vectors++;
      if (observed() !== {M_STOP, 3'b100, 3'd0}) begin
         miscompares++;
         $display("[TB] FAIL restart_from_done: got %b expected %b", observed(), {M_STOP, 3'b100, 3'd0});
      end
      steps.push_back(step(3'b110, M_GLEFT, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b100, M_SLEFT, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b011, M_GRIGHT, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b001, M_SRIGHT, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b101, M_FWD, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b111, M_FWD, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b010, M_FWD, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b111, M_FWD, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b110, M_GLEFT, 1, 0, 0, 3'd0));
      foreach (steps[i]) begin
         apply_step(steps[i]);
         exp = sb.pop_front();
         vectors++;
         if (observed() !== exp) begin
            miscompares++;
            $display("[TB] FAIL steering step %0d: got %b expected %b", i, observed(), exp);
         end
      end
   endtask

   task automatic test_lost();
      logic [9:0] exp;
      for (int k = 1; k <= 25; k++) begin
         apply_step(step(3'b000, (k < 25) ? M_GLEFT : M_STOP, k < 25, 0, k == 25, 3'd0));
         exp = sb.pop_front();
         vectors++;
         if (observed() !== exp) begin
            miscompares++;
            $display("[TB] FAIL lost frame %0d: got %b expected %b", k, observed(), exp);
         end
      end
      pulse_start();
      vectors++;
      if (observed() !== {M_STOP, 3'b100, 3'd0}) begin
         miscompares++;
         $display("[TB] FAIL restart_from_fault: got %b expected %b", observed(), {M_STOP, 3'b100, 3'd0});
      end
      apply_step(step(3'b010, M_FWD, 1, 0, 0, 3'd0));
      exp = sb.pop_front();
      vectors++;
      if (observed() !== exp) begin
         miscompares++;
         $display("[TB] FAIL lost_recover: got %b expected %b", observed(), exp);
      end
   endtask

   task automatic test_turn_timeout();
      logic [12:0] steps[$];
      logic [9:0] exp;
      route_cmd = 16'h0002;
      route_len = 4'd1;
      pulse_start();
      vectors++;
      if (observed() !== {M_FWD, 3'b100, 3'd0}) begin
         miscompares++;
         $display("[TB] FAIL start_while_busy: got %b expected %b", observed(), {M_FWD, 3'b100, 3'd0});
      end
      // The earlier route (slot 0 = left) must still be in force.
      steps.push_back(step(3'b111, M_FWD, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b111, M_SLEFT, 1, 0, 0, 3'd1));
      foreach (steps[i]) begin
         apply_step(steps[i]);
         exp = sb.pop_front();
         vectors++;
         if (observed() !== exp) begin
            miscompares++;
            $display("[TB] FAIL busy_route step %0d: got %b expected %b", i, observed(), exp);
         end
      end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      vectors++;
      if (observed() !== {M_STOP, 6'd0}) begin
         miscompares++;
         $display("[TB] FAIL reset_mid_turn: got %b expected %b", observed(), {M_STOP, 6'd0});
      end
      pulse_start();
      steps.delete();
      steps.push_back(step(3'b111, M_FWD, 1, 0, 0, 3'd0));
      steps.push_back(step(3'b111, M_SRIGHT, 1, 0, 0, 3'd1));
      for (int k = 1; k <= 100; k++)
         steps.push_back(step(3'b101, (k < 100) ? M_SRIGHT : M_STOP, k < 100, 0, k == 100, 3'd1));
      foreach (steps[i]) begin
         apply_step(steps[i]);
         exp = sb.pop_front();
         vectors++;
         if (observed() !== exp) begin
            miscompares++;
            $display("[TB] FAIL turn_timeout step %0d: got %b expected %b", i, observed(), exp);
         end
      end
   endtask

   initial begin
      test_reset();
      test_route();
      test_steering();
      test_lost();
      test_turn_timeout();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
